if_fetch_stage: RTL and testbench

Instruction-fetch stage sitting between the PC register and the decode stage of the 5-stage MIPS pipeline. It takes the current PC and issues a request/ready fetch to instruction memory, which may have variable latency. It produces pc_4_if and the pc_write enable back to the PC register. It holds the IF/ID pipeline register (instruction, PC+4, valid) and has a one-entry skid buffer so a response that arrives while decode is stalled is never lost.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_skid_buf.sv | 48 ++++
 rtl/if_fetch_stage.sv | 153 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage.
package if_pkg;

  typedef logic [1:0] if_state_t;

  localparam if_state_t ST_REQ   = 2'd0;
  localparam if_state_t ST_FULL  = 2'd1;
  localparam if_state_t ST_DRAIN = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {inst, pc_4} holding register used when decode cannot accept a response.
module if_skid_buf
  import if_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [DW-1:0] NOP = DW'(NOP_INST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          unload_i,
  input  logic          clear_i,
  input  logic [DW-1:0] inst_i,
  input  logic [AW-1:0] pc_4_i,
  output logic          full_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] pc_4_o
);

  logic          full_q;
  logic [DW-1:0] inst_q;
  logic [AW-1:0] pc_4_q;

  // clear beats load so a flush can never leave stale data behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      inst_q <= NOP;
      pc_4_q <= {AW{1'b0}};
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
      inst_q <= inst_i;
      pc_4_q <= pc_4_i;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_q;
    end
  end

  assign full_o = full_q;
  assign inst_o = inst_q;
  assign pc_4_o = pc_4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: request/ready fetch from imem, IF/ID register and
// a one-entry skid buffer for responses that arrive while decode is stalled.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [DW-1:0] NOP = DW'(NOP_INST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  output logic [AW-1:0] pc_4_if,
  output logic          pc_write,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [DW-1:0] imem_rdata,
  input  logic          stall,
  input  logic          flush,
  output logic          valid_id,
  output logic [DW-1:0] inst_id,
  output logic [AW-1:0] pc_4_id
);

  if_state_t     state_q, state_d;
  logic          outst_q, outst_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] inst_q, inst_d;
  logic [AW-1:0] pc4_q, pc4_d;

  logic          req_s, resp_s, can_accept_s, pc_write_s;
  logic          skid_load_s, skid_unload_s, skid_clear_s, skid_full_s;
  logic [DW-1:0] skid_inst_s;
  logic [AW-1:0] skid_pc4_s;

  assign pc_4_if      = pc_in + AW'(PC_STEP);
  assign can_accept_s = !valid_q || !stall;
  assign req_s        = !rst && ((state_q == ST_REQ) || (state_q == ST_DRAIN));
  assign resp_s       = req_s && imem_ready;

  assign imem_req  = req_s;
  assign imem_addr = (outst_q || (state_q == ST_DRAIN)) ? addr_q : pc_in;
  assign pc_write  = pc_write_s && !rst;

  if_skid_buf #(.AW(AW), .DW(DW), .NOP(NOP)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load_s),
    .unload_i (skid_unload_s),
    .clear_i  (skid_clear_s),
    .inst_i   (imem_rdata),
    .pc_4_i   (pc_4_if),
    .full_o   (skid_full_s),
    .inst_o   (skid_inst_s),
    .pc_4_o   (skid_pc4_s)
  );

  // Next-state logic; flush overrides everything, including stall
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    inst_d        = inst_q;
    pc4_d         = pc4_q;
    pc_write_s    = 1'b0;
    skid_load_s   = 1'b0;
    skid_unload_s = 1'b0;
    skid_clear_s  = 1'b0;
    outst_d       = req_s && !imem_ready;

    // the address is latched on first issue so it stays stable while the PC moves
    if (req_s && !outst_q && (state_q == ST_REQ)) begin
      addr_d = pc_in;
    end else begin
      addr_d = addr_q;
    end

    if (flush) begin
      pc_write_s   = 1'b1;
      valid_d      = 1'b0;
      inst_d       = NOP;
      skid_clear_s = 1'b1;
      state_d      = (req_s && !imem_ready) ? ST_DRAIN : ST_REQ;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (resp_s) begin
            pc_write_s = 1'b1;
            if (can_accept_s) begin
              valid_d = 1'b1;
              inst_d  = imem_rdata;
              pc4_d   = pc_4_if;
            end else begin
              skid_load_s = 1'b1;
              state_d     = ST_FULL;
            end
          end else if (valid_q && !stall) begin
            valid_d = 1'b0;
            inst_d  = NOP;
          end else begin
            valid_d = valid_q;
          end
        end
        ST_FULL: begin
          if (!stall) begin
            valid_d       = skid_full_s;
            inst_d        = skid_inst_s;
            pc4_d         = skid_pc4_s;
            skid_unload_s = 1'b1;
            state_d       = ST_REQ;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_DRAIN: begin
          if (imem_ready) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  // State and IF/ID pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
      outst_q <= 1'b0;
      addr_q  <= {AW{1'b0}};
      valid_q <= 1'b0;
      inst_q  <= NOP;
      pc4_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_id = valid_q;
  assign inst_id  = inst_q;
  assign pc_4_id  = pc4_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: queue-based reference model,
// variable-latency memory and PC register living in the bench.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] pc_4_if;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        valid_id;
  logic [31:0] inst_id;
  logic [31:0] pc_4_id;

  int checks = 0;
  int errors = 0;

  if_fetch_stage #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_4_if    (pc_4_if),
    .pc_write   (pc_write),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .flush      (flush),
    .valid_id   (valid_id),
    .inst_id    (inst_id),
    .pc_4_id    (pc_4_id)
  );

  always #5 clk = ~clk;

  // Reference model: queue of held {inst, pc_4} (head = IF/ID, second = skid)
  logic [63:0] mq[$];
  logic        m_drain, m_wait, m_req, m_rdy, m_pcw;
  logic [31:0] m_lock, m_addr, pc, cur_rdata, cur_tgt;
  logic        cur_st, cur_fl;
  int          mem_cnt, lat;
  bit          rand_lat, spur_en;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_pc4;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drain = 1'b0;
    m_wait  = 1'b0;
    m_lock  = 32'h0;
    mem_cnt = 0;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    rst        = 1'b1;
    stall      = 1'b0;
    flush      = 1'b0;
    imem_ready = 1'b0;
    model_reset();
    pc    = pc0;
    pc_in = pc0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Apply one cycle of inputs and compare DUT against the model
  task automatic drive(input logic st, input logic fl, input logic [31:0] tgt);
    cur_st  = st;
    cur_fl  = fl;
    cur_tgt = tgt;
    m_req   = m_drain || (mq.size() < 2);
    m_addr  = m_wait ? m_lock : pc;
    if (m_req) m_rdy = (mem_cnt >= lat);
    else       m_rdy = spur_en && ($urandom_range(0, 3) == 0);
    m_pcw     = fl || (m_req && m_rdy && !m_drain);
    cur_rdata = m_rdy ? (m_addr | 32'hA000_0000) : $urandom;
    stall      = st;
    flush      = fl;
    pc_in      = pc;
    imem_ready = m_rdy;
    imem_rdata = cur_rdata;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    chk("pc_write", {31'd0, pc_write}, {31'd0, m_pcw});
    chk("pc_4_if", pc_4_if, pc + 32'd4);
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("valid_id", {31'd0, valid_id}, {31'd0, (mq.size() > 0)});
    if (mq.size() > 0) begin
      chk("inst_id", inst_id, mq[0][63:32]);
      chk("pc_4_id", pc_4_id, mq[0][31:0]);
    end else begin
      chk("inst_nop", inst_id, 32'h0000_0000);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (cur_fl) begin
      mq.delete();
      m_drain = m_req && !m_rdy;
    end else if (m_drain) begin
      if (m_rdy) m_drain = 1'b0;
    end else begin
      if (!cur_st && mq.size() > 0) void'(mq.pop_front());
      if (m_req && m_rdy) mq.push_back({cur_rdata, pc + 32'd4});
    end
    if (m_req && !m_wait) m_lock = pc;
    m_wait = m_req && !m_rdy;
    if (m_pcw) pc = cur_fl ? cur_tgt : pc + 32'd4;
    if (m_req) begin
      if (m_rdy) begin
        mem_cnt = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else begin
        mem_cnt++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rand_lat   = 1'b0;
    spur_en    = 1'b0;
    lat        = 0;
    rst        = 1'b1;
    stall      = 1'b0;
    flush      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    pc_in      = 32'h0;
    model_reset();

    vecs[0] = '{32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{32'h0000_0010, 32'h0000_0014};
    vecs[2] = '{32'h1234_5678, 32'h1234_567C};
    vecs[3] = '{32'h7FFF_FFFC, 32'h8000_0000};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFFE, 32'h0000_0002};
    for (int i = 0; i < 6; i++) begin
      pc_in = vecs[i].pc;
      #1;
      chk("tbl_pc_4_if", pc_4_if, vecs[i].exp_pc4);
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
      chk("rst_valid", {31'd0, valid_id}, 32'd0);
      chk("rst_inst", inst_id, 32'h0000_0000);
      chk("rst_pc_4_id", pc_4_id, 32'h0000_0000);
    end

    // zero-wait streaming from pc 0
    do_reset(32'h0);
    drive(1'b0, 1'b0, 32'h0); chk("s1_pcw0", {31'd0, pc_write}, 32'd1); advance();
    drive(1'b0, 1'b0, 32'h0); chk("s1_inst0", inst_id, 32'hA000_0000); advance();
    drive(1'b0, 1'b0, 32'h0); chk("s1_inst1", inst_id, 32'hA000_0004);
    chk("s1_pcw2", {31'd0, pc_write}, 32'd1); advance();
    drive(1'b0, 1'b0, 32'h0); chk("s1_inst2", inst_id, 32'hA000_0008); advance();

    // stall with a response for 0x10 lands in the skid
    drive(1'b1, 1'b0, 32'h0);
    chk("s2_addr", imem_addr, 32'h0000_0010);
    chk("s2_pcw", {31'd0, pc_write}, 32'd1); advance();
    drive(1'b1, 1'b0, 32'h0);
    chk("s2_req_off", {31'd0, imem_req}, 32'd0);
    chk("s2_pcw_off", {31'd0, pc_write}, 32'd0);
    chk("s2_hold", inst_id, 32'hA000_000C); advance();
    drive(1'b0, 1'b0, 32'h0); advance();
    drive(1'b0, 1'b0, 32'h0);
    chk("s2_skid_inst", inst_id, 32'hA000_0010);
    chk("s2_skid_pc4", pc_4_id, 32'h0000_0014);
    chk("s2_next_addr", imem_addr, 32'h0000_0014);

    // skid full, then flush together with stall
    drive(1'b1, 1'b0, 32'h0); advance();
    drive(1'b1, 1'b1, 32'h200); chk("s4_pcw", {31'd0, pc_write}, 32'd1); advance();
    drive(1'b1, 1'b0, 32'h0);
    chk("s4_valid", {31'd0, valid_id}, 32'd0);
    chk("s4_req", {31'd0, imem_req}, 32'd1);
    chk("s4_addr", imem_addr, 32'h0000_0200); advance();
    drive(1'b0, 1'b0, 32'h0); chk("s4_inst", inst_id, 32'hA000_0200); advance();

    // ready and flush in the same cycle
    drive(1'b0, 1'b1, 32'h300); chk("s5_pcw", {31'd0, pc_write}, 32'd1); advance();
    drive(1'b0, 1'b0, 32'h0);
    chk("s5_valid", {31'd0, valid_id}, 32'd0);
    chk("s5_addr", imem_addr, 32'h0000_0300); advance();
    drive(1'b0, 1'b0, 32'h0); chk("s5_inst", inst_id, 32'hA000_0300); advance();

    // reset in the middle of a 3-cycle wait
    lat = 3;
    drive(1'b0, 1'b0, 32'h0); advance();
    drive(1'b0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("s6_req", {31'd0, imem_req}, 32'd0);
    chk("s6_pcw", {31'd0, pc_write}, 32'd0);
    chk("s6_valid", {31'd0, valid_id}, 32'd0);
    chk("s6_inst", inst_id, 32'h0000_0000);
    chk("s6_pc4", pc_4_id, 32'h0000_0000);
    lat = 0;
    do_reset(32'h400);
    drive(1'b0, 1'b0, 32'h0);
    chk("s6_addr", imem_addr, 32'h0000_0400);
    chk("s6_req_on", {31'd0, imem_req}, 32'd1); advance();

    // 3-cycle memory, flush in wait cycle 1 forces a drain
    lat = 3;
    do_reset(32'h20);
    drive(1'b0, 1'b0, 32'h0); chk("s3_addr0", imem_addr, 32'h0000_0020); advance();
    drive(1'b0, 1'b1, 32'h100); chk("s3_pcw", {31'd0, pc_write}, 32'd1); advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      chk("s3_drain_addr", imem_addr, 32'h0000_0020);
      chk("s3_drain_req", {31'd0, imem_req}, 32'd1);
      chk("s3_drain_pcw", {31'd0, pc_write}, 32'd0);
      chk("s3_drain_valid", {31'd0, valid_id}, 32'd0);
      advance();
    end
    lat = 0;
    drive(1'b0, 1'b0, 32'h0);
    chk("s3_new_addr", imem_addr, 32'h0000_0100);
    chk("s3_still_invalid", {31'd0, valid_id}, 32'd0); advance();
    drive(1'b0, 1'b0, 32'h0); chk("s3_inst", inst_id, 32'hA000_0100); advance();

    // randomized traffic against the model, including a PC wrap
    rand_lat = 1'b1;
    spur_en  = 1'b1;
    do_reset(32'hFFFF_FFF0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset($urandom & 32'hFFFF_FFFC);
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), $urandom & 32'hFFFF_FFFC);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
